// File: rtl/full_subtractor_64bit_pkg.sv
// Shared ALU constants for the registered ripple-borrow subtractor.
// Holds the datapath width used by the interface and the top level.
package full_subtractor_64bit_pkg;

    localparam int FS_WIDTH = 64;

endpackage

// File: rtl/full_subtractor_64bit_if.sv
// Operand/result bundle for the registered subtractor.
// master drives in_valid/A/B/Bin; slave returns out_valid/Diff/Bout.
interface full_subtractor_64bit_if
    import full_subtractor_64bit_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output in_valid,
        output A,
        output B,
        output Bin,
        input  out_valid,
        input  Diff,
        input  Bout
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Bin,
        output out_valid,
        output Diff,
        output Bout
    );

endinterface

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow-out.
// Ports: a, b, bin in; d, bout out.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;
    // Borrow when b exceeds a, or when a==b and a borrow arrives.
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/full_subtractor_64bit.sv
// Registered ripple-borrow subtractor: {Bout,Diff} = A - B - Bin, 1-cycle latency.
// Ports: clk, rst_n (async active-low), bus (slave: operands in, result out).
module full_subtractor_64bit
    import full_subtractor_64bit_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    full_subtractor_64bit_if.slave bus
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_c;

    assign borrow[0] = bus.Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor_1bit u_bit (
            .a    (bus.A[i]),
            .b    (bus.B[i]),
            .bin  (borrow[i]),
            .d    (diff_c[i]),
            .bout (borrow[i+1])
        );
    end

    logic [WIDTH-1:0] diff_d, diff_q;
    logic             bout_d, bout_q;
    logic             valid_d, valid_q;

    // Idle cycles drop out_valid but keep the last result visible.
    always_comb begin
        diff_d  = diff_q;
        bout_d  = bout_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            diff_d  = diff_c;
            bout_d  = borrow[WIDTH];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q  <= '0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor_64bit.sv
// Self-checking bench for full_subtractor_64bit: directed literals plus
// an arithmetic reference model compared on every falling edge.
module tb_full_subtractor_64bit;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    full_subtractor_64bit_if #(.WIDTH(W)) bus ();

    full_subtractor_64bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: plain 65-bit arithmetic on the sampled operands.
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_valid;

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] r;
        if (!rst_n) begin
            m_diff  <= '0;
            m_bout  <= 1'b0;
            m_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r = {1'b0, bus.A} - {1'b0, bus.B} - {{W{1'b0}}, bus.Bin};
            m_diff  <= r[W-1:0];
            m_bout  <= r[W];
            m_valid <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_diff", bus.Diff, m_diff);
            chk("model_bout", {{(W-1){1'b0}}, bus.Bout}, {{(W-1){1'b0}}, m_bout});
            chk("model_valid", {{(W-1){1'b0}}, bus.out_valid},
                {{(W-1){1'b0}}, m_valid});
        end
    end

    task automatic lit(input string name, input logic [W-1:0] d,
                       input logic bo, input logic v);
        chk({name, "_diff"}, bus.Diff, d);
        chk({name, "_bout"}, {{(W-1){1'b0}}, bus.Bout}, {{(W-1){1'b0}}, bo});
        chk({name, "_valid"}, {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, v});
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic v);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        bus.in_valid = v;
    endtask

    task automatic vec(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] d, input logic bo);
        drive(a, b, bin, 1'b1);
        @(posedge clk);
        #1;
        lit(name, d, bo, 1'b1);
    endtask

    initial begin
        bus.A        = 64'hDEAD_BEEF_0123_4567;
        bus.B        = 64'h1111_2222_3333_4444;
        bus.Bin      = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_hold", 64'h0, 1'b0, 1'b0);
        chk_en = 1'b1;

        drive(64'h64, 64'h32, 1'b0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lit("first_after_reset", 64'h32, 1'b0, 1'b1);

        vec("neg_minus_pos", 64'hFFFF_FFFF_FFFF_FFCE, 64'h19, 1'b0,
            64'hFFFF_FFFF_FFFF_FFB5, 1'b0);
        vec("borrow_in", 64'h19, 64'h32, 1'b1,
            64'hFFFF_FFFF_FFFF_FFE6, 1'b1);
        vec("equal_bin", 64'h5, 64'h5, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        vec("max_borrow", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'h0, 1'b1);

        vec("b2b_1", 64'h1000, 64'h1, 1'b0, 64'hFFF, 1'b0);
        vec("b2b_2", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFE, 1'b0);
        vec("b2b_3", 64'h7, 64'h9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        drive(64'h1234, 64'h1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        lit("idle_hold", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        lit("idle_hold2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        vec("pre_reset", 64'hA, 64'h3, 1'b0, 64'h7, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        lit("async_reset", 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) != 0));
        end
        @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
